ahb_ram_arbiter: RTL

//  Two-master arbiter and access sequencer for the single-port AHB RAM.

---
 rtl/ahb_ram_arb_pkg.sv | 11 +
 rtl/ahb_ram_arbiter_rr_arbiter2.sv | 23 ++
 rtl/ahb_ram_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ahb_ram_arb_pkg.sv
// Shared types for the two-master AHB RAM arbiter.
package ahb_ram_arb_pkg;

  typedef enum logic {IDLE, WAIT} arb_state_t;

  typedef logic mst_idx_t;

  localparam mst_idx_t M0 = 1'b0;
  localparam mst_idx_t M1 = 1'b1;

endpackage

// File: rtl/ahb_ram_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick, purely combinational; on contention the
// requester that was not granted last wins.
module rr_arbiter2
  import ahb_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last_grant,
  output mst_idx_t   grant,
  output logic       any_req
);

  always_comb begin
    grant = M0;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = M1;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ahb_ram_arbiter.sv
// Arbitrates M0/M1 onto a single-port RAM; 1+WAIT_STATES cycles per access,
// requesters that are not being served are stalled through their own HREADY.
module ahb_ram_arbiter
  import ahb_ram_arb_pkg::*;
#(
  parameter int          AW          = 15,
  parameter int          DW          = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL0,
  input  logic [AW-1:0] HADDR0,
  input  logic          HWRITE0,
  input  logic [DW-1:0] HWDATA0,
  output logic          HREADY0,
  output logic [DW-1:0] HRDATA0,
  input  logic          HSEL1,
  input  logic [AW-1:0] HADDR1,
  input  logic          HWRITE1,
  input  logic [DW-1:0] HWDATA1,
  output logic          HREADY1,
  output logic [DW-1:0] HRDATA1,
  output logic          RAM_HSEL,
  output logic [AW-1:0] RAM_HADDR,
  output logic          RAM_HWRITE,
  output logic [DW-1:0] RAM_HWDATA,
  input  logic [DW-1:0] RAM_HRDATA
);

  if (WAIT_STATES > 7) begin : g_ws_check
    $error("ahb_ram_arbiter: WAIT_STATES must be in 0..7");
  end

  localparam logic [2:0] WCNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  arb_state_t state_q, state_d;
  mst_idx_t   owner_q, owner_d;
  mst_idx_t   last_grant_q, last_grant_d;
  logic [2:0] wcnt_q, wcnt_d;

  logic [1:0] req;
  mst_idx_t   grant;
  logic       any_req;
  mst_idx_t   sel;
  logic [1:0] hready;

  assign req = {HSEL1, HSEL0};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_req    (any_req)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wcnt_d       = wcnt_q;
    sel          = grant;
    RAM_HSEL     = 1'b0;
    RAM_HWRITE   = 1'b0;
    hready       = 2'b11;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          sel      = grant;
          RAM_HSEL = 1'b1;
          // every requester stalls unless it completes this cycle
          hready   = ~req;
          if (WAIT_STATES == 0) begin
            hready[grant] = 1'b1;
            RAM_HWRITE    = (grant == M1) ? HWRITE1 : HWRITE0;
            last_grant_d  = grant;
          end else begin
            owner_d = grant;
            wcnt_d  = WCNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        sel             = owner_q;
        RAM_HSEL        = 1'b1;
        hready          = ~req;
        hready[owner_q] = 1'b0;
        if (wcnt_q == 3'd0) begin
          hready[owner_q] = 1'b1;
          RAM_HWRITE      = (owner_q == M1) ? HWRITE1 : HWRITE0;
          last_grant_d    = owner_q;
          state_d         = IDLE;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // reset wins over everything: bus parked, nobody stalled, no write
    if (HRESET) begin
      RAM_HSEL   = 1'b0;
      RAM_HWRITE = 1'b0;
      hready     = 2'b11;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= IDLE;
      owner_q      <= M0;
      last_grant_q <= M1;
      wcnt_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wcnt_q       <= wcnt_d;
    end
  end

  assign RAM_HADDR  = (sel == M1) ? HADDR1 : HADDR0;
  assign RAM_HWDATA = (sel == M1) ? HWDATA1 : HWDATA0;
  assign HREADY0    = hready[0];
  assign HREADY1    = hready[1];
  assign HRDATA0    = (RAM_HSEL && sel == M0) ? RAM_HRDATA : '0;
  assign HRDATA1    = (RAM_HSEL && sel == M1) ? RAM_HRDATA : '0;

endmodule
